trivium_encrypt_state: RTL and testbench



---
 rtl/trivium_pkg.sv | 60 ++++++
 rtl/trivium_round.sv | 41 ++++
 rtl/trivium_encrypt_state.sv | 46 ++++
 tb/tb_trivium_encrypt_state.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared Trivium widths, tap positions and load-pattern helper
//
// Purpose:
//   Constants shared by the Trivium state engine and its round function.
//   Tap positions are 1-based (s1..s288), matching the usual Trivium notation.
//   State bit s_i lives at vector index i-1.
//
// Contents:
//   KEY_W, IV_W, ST_W          key, IV and state widths.
//   TAP_*                      round tap positions (1-based).
//   A_LO, B_LO, C_LO           vector index of the first bit of each of the three shift registers.
//   tap(state, pos)            returns s_pos from a packed state vector.
//   trivium_load(key, iv)      returns the 288-bit state loaded at reset.

package trivium_pkg;

  localparam int KEY_W = 80;
  localparam int IV_W  = 80;
  localparam int ST_W  = 288;

  // Register A is s1..s93, register B is s94..s177, register C is s178..s288.
  localparam int A_LO = 0;
  localparam int B_LO = 93;
  localparam int C_LO = 177;

  // Linear taps that also form the keystream bit.
  localparam int TAP_T1_A = 66;
  localparam int TAP_T1_B = 93;
  localparam int TAP_T2_A = 162;
  localparam int TAP_T2_B = 177;
  localparam int TAP_T3_A = 243;
  localparam int TAP_T3_B = 288;

  // AND-pair and cross-register feedback taps.
  localparam int TAP_T1_AND_A = 91;
  localparam int TAP_T1_AND_B = 92;
  localparam int TAP_T1_FB    = 171;
  localparam int TAP_T2_AND_A = 175;
  localparam int TAP_T2_AND_B = 176;
  localparam int TAP_T2_FB    = 264;
  localparam int TAP_T3_AND_A = 286;
  localparam int TAP_T3_AND_B = 287;
  localparam int TAP_T3_FB    = 69;

  function automatic logic tap(input logic [ST_W-1:0] state, input int pos);
    return state[pos-1];
  endfunction

  // Key into s1..s80, IV into s94..s173, s286..s288 set, everything else clear.
  function automatic logic [ST_W-1:0] trivium_load(input logic [KEY_W-1:0] key,
                                                   input logic [IV_W-1:0]  iv);
    logic [ST_W-1:0] s;
    s                 = '0;
    s[A_LO +: KEY_W]  = key;
    s[B_LO +: IV_W]   = iv;
    s[ST_W-1 -: 3]    = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// rtl/trivium_round.sv - one combinational Trivium round
//
// Purpose:
//   Computes the next Trivium state and the keystream bit of the current state.
//
// Ports:
//   state_in   in   288  current state, s_i = state_in[i-1]
//   state_out  out  288  state after one round
//   z          out  1    keystream bit taken from state_in (before feedback is mixed in)

module trivium_round
  import trivium_pkg::*;
(
  input  logic [ST_W-1:0] state_in,
  output logic [ST_W-1:0] state_out,
  output logic            z
);

  logic t1_lin, t2_lin, t3_lin;
  logic t1, t2, t3;

  always_comb begin
    t1_lin = tap(state_in, TAP_T1_A) ^ tap(state_in, TAP_T1_B);
    t2_lin = tap(state_in, TAP_T2_A) ^ tap(state_in, TAP_T2_B);
    t3_lin = tap(state_in, TAP_T3_A) ^ tap(state_in, TAP_T3_B);

    // z uses only the linear parts; the nonlinear terms feed the state only.
    z = t1_lin ^ t2_lin ^ t3_lin;

    t1 = t1_lin ^ (tap(state_in, TAP_T1_AND_A) & tap(state_in, TAP_T1_AND_B)) ^ tap(state_in, TAP_T1_FB);
    t2 = t2_lin ^ (tap(state_in, TAP_T2_AND_A) & tap(state_in, TAP_T2_AND_B)) ^ tap(state_in, TAP_T2_FB);
    t3 = t3_lin ^ (tap(state_in, TAP_T3_AND_A) & tap(state_in, TAP_T3_AND_B)) ^ tap(state_in, TAP_T3_FB);

    // Each register shifts toward its high end; the feedback of one register
    // enters the bottom of the next (t3 -> A, t1 -> B, t2 -> C).
    state_out = {state_in[ST_W-2:C_LO], t2,
                 state_in[C_LO-2:B_LO], t1,
                 state_in[B_LO-2:A_LO], t3};
  end

endmodule

// File: rtl/trivium_encrypt_state.sv
// rtl/trivium_encrypt_state.sv - free-running Trivium state register, one round per clock
//
// Purpose:
//   Holds the 288-bit Trivium state. Reset asynchronously loads the key/IV
//   pattern; every rising clock edge without reset applies one round.
//
// Ports:
//   clk    in   1    rising-edge clock
//   reset  in   1    asynchronous, active-high; forces the key/IV load pattern
//   KEY    in   80   cipher key, K_i = KEY[i-1]
//   IV     in   80   initialisation vector, IV_i = IV[i-1]
//   STR    out  288  registered state, s_i = STR[i-1]

module trivium_encrypt_state
  import trivium_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] KEY,
  input  logic [IV_W-1:0]  IV,
  output logic [ST_W-1:0]  STR
);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  logic            z_unused;

  trivium_round u_round (
    .state_in  (state_q),
    .state_out (state_d),
    .z         (z_unused)
  );

  // KEY/IV reach the state only through the asynchronous load, so changing
  // them while reset is low has no effect on the running state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= trivium_load(KEY, IV);
    end else begin
      state_q <= state_d;
    end
  end

  assign STR = state_q;

endmodule

// File: tb/tb_trivium_encrypt_state.sv
// tb/tb_trivium_encrypt_state.sv - self-checking bench for trivium_encrypt_state

module tb_trivium_encrypt_state;

  logic         clk;
  logic         reset;
  logic [79:0]  KEY;
  logic [79:0]  IV;
  logic [287:0] STR;

  int passed;
  int total;

  // Reference state, 1-based: ms[i] is s_i.
  bit ms [1:288];

  logic [287:0] exp_q [$];

  trivium_encrypt_state dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .IV    (IV),
    .STR   (STR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  function automatic void model_load(input logic [79:0] k, input logic [79:0] iv);
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) ms[i] = k[i-1];
    for (int i = 1; i <= 80; i++) ms[93+i] = iv[i-1];
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
  endfunction

  function automatic bit model_z();
    return ms[66] ^ ms[93] ^ ms[162] ^ ms[177] ^ ms[243] ^ ms[288];
  endfunction

  function automatic void model_step();
    bit a, b, c;
    a = ms[66]  ^ ms[93]  ^ (ms[91]  & ms[92])  ^ ms[171];
    b = ms[162] ^ ms[177] ^ (ms[175] & ms[176]) ^ ms[264];
    c = ms[243] ^ ms[288] ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
    ms[178] = b;
    for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
    ms[94] = a;
    for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
    ms[1] = c;
  endfunction

  function automatic logic [287:0] model_vec();
    logic [287:0] v;
    for (int i = 1; i <= 288; i++) v[i-1] = ms[i];
    return v;
  endfunction

  initial begin
    logic [79:0] k0, i0;
    logic        zd;
    passed = 0;
    total  = 0;
    k0 = 80'h00112233445566778899;
    i0 = 80'h00000123456789abcdef;

    // Reset load pattern
    reset = 1'b1;
    KEY   = k0;
    IV    = i0;
    model_load(k0, i0);
    #2;
    check("load_full", STR, model_vec());
    check("load_key",  288'(STR[79:0]),    288'(k0));
    check("load_gap",  288'(STR[92:80]),   288'd0);
    check("load_iv",   288'(STR[172:93]),  288'(i0));
    check("load_zero", 288'(STR[284:173]), 288'd0);
    check("load_ones", 288'(STR[287:285]), 288'd7);

    // First round
    @(negedge clk);
    reset = 1'b0;
    step();
    model_step();
    check("r1_full",  STR, model_vec());
    check("r1_s1",    288'(STR[0]),       288'd1);
    check("r1_key",   288'(STR[80:1]),    288'(k0));
    check("r1_s94",   288'(STR[93]),      288'd0);
    check("r1_iv",    288'(STR[173:94]),  288'(i0));
    check("r1_s178",  288'(STR[177]),     288'd0);
    check("r1_s286",  288'(STR[285]),     288'd0);
    check("r1_top",   288'(STR[287:286]), 288'd3);

    // All-zero key/IV, 10 rounds
    @(negedge clk);
    reset = 1'b1;
    KEY   = '0;
    IV    = '0;
    model_load('0, '0);
    #1;
    check("zero_load", STR, model_vec());
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      model_step();
      check($sformatf("zero_r%0d", n), STR, model_vec());
    end

    // Random key/IV pairs
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      reset = 1'b1;
      KEY   = rand80();
      IV    = rand80();
      model_load(KEY, IV);
      #1;
      check($sformatf("rnd%0d_load", r), STR, model_vec());
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 40; n++) begin
        step();
        model_step();
        if (n % 8 == 0) check($sformatf("rnd%0d_r%0d", r, n), STR, model_vec());
      end
    end

    // Long run with warm-up, keystream and KEY/IV change while running
    @(negedge clk);
    reset = 1'b1;
    KEY   = k0;
    IV    = i0;
    model_load(k0, i0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      step();
      model_step();
      if (n <= 20) exp_q.push_back(model_vec());
      if (n == 1152 || n == 2501 || n == 5000) check($sformatf("long_r%0d", n), STR, model_vec());
      if (n >= 1152 && n % 16 == 0) begin
        zd = STR[65] ^ STR[92] ^ STR[161] ^ STR[176] ^ STR[242] ^ STR[287];
        check($sformatf("z_r%0d", n), 288'(zd), 288'(model_z()));
      end
      if (n == 2500) begin
        KEY = rand80();
        IV  = rand80();
      end
    end

    // Reset between edges mid-run, then replay from round 1
    KEY = k0;
    IV  = i0;
    @(negedge clk);
    reset = 1'b1;
    model_load(k0, i0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      step();
      model_step();
    end
    check("mid_r300", STR, model_vec());
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_load(k0, i0);
    #1;
    check("mid_async_load", STR, model_vec());
    @(posedge clk);
    #1;
    check("mid_hold_load", STR, model_vec());
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      check($sformatf("replay_r%0d", n), STR, exp_q[n-1]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
